// File: rtl/hicore_bypq_pkg.sv
// Shared defaults and helpers for the hicore bypass queue.
// Pipeline instances pick up the default depth and width from here.
package hicore_bypq_pkg;

  localparam int unsigned BYPQ_DP_DEF = 4;
  localparam int unsigned BYPQ_DW_DEF = 32;

  // Half-full threshold uses integer division, so odd depths round down.
  function automatic int unsigned bypq_half(input int unsigned dp);
    return dp / 2;
  endfunction

endpackage

// File: rtl/hicore_bypq_ptr.sv
// Circular index for the bypass queue storage.
// It wraps at DP-1 so non-power-of-two depths work.
module hicore_bypq_ptr
  import hicore_bypq_pkg::*;
#(
  parameter int unsigned DP = BYPQ_DP_DEF,
  parameter int unsigned PW = $clog2(DP)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST = PW'(DP - 1);

  logic [PW-1:0] ptr_nxt;

  always_comb begin
    ptr_nxt = ptr;
    if (clr) begin
      ptr_nxt = '0;
    end else if (inc) begin
      ptr_nxt = (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/hicore_bypq.sv
// Bypass queue: elastic buffer of DP entries with an optional zero-latency
// pass-through when empty and optional internal dropping of cancelled entries.
module hicore_bypq
  import hicore_bypq_pkg::*;
#(
  parameter int unsigned DP          = BYPQ_DP_DEF,
  parameter int unsigned DW          = BYPQ_DW_DEF,
  parameter bit          BYPASS      = 1'b1,
  parameter bit          DROP_CANCEL = 1'b0,
  parameter int unsigned AF_TH       = DP - 1,
  parameter int unsigned CW          = $clog2(DP + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  input  logic          i_cancel,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat,
  output logic          o_cancel,
  output logic [CW-1:0] o_cnt,
  output logic          o_empty,
  output logic          o_half_full,
  output logic          o_afull
);

  localparam int unsigned PW = $clog2(DP);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [DW-1:0] mem_dat [DP];
  logic [DP-1:0] mem_cnl;

  logic st_nz;
  logic full;
  logic head_cnl_st;
  logic drop_in;
  logic drop_st;
  logic byp;
  logic head_vld;
  logic head_drop;
  logic push;
  logic pop;

  assign st_nz       = (cnt != '0);
  assign full        = (cnt == CW'(DP));
  assign head_cnl_st = mem_cnl[rd_ptr];

  // A cancelled input arriving on an empty queue is consumed by the bypass
  // path even when downstream is stalled, so it never occupies a slot.
  assign drop_in = DROP_CANCEL & i_cancel;
  assign byp     = BYPASS & ~st_nz & i_vld & (o_rdy | drop_in);
  assign drop_st = DROP_CANCEL & st_nz & head_cnl_st & ~flush;

  assign i_rdy = ~full & ~flush;

  always_comb begin
    head_vld  = st_nz | (BYPASS & i_vld);
    head_drop = st_nz ? (DROP_CANCEL & head_cnl_st) : drop_in;
    o_vld     = ~flush & head_vld & ~head_drop;
    if (st_nz | ~BYPASS) begin
      o_dat    = mem_dat[rd_ptr];
      o_cancel = head_cnl_st;
    end else begin
      o_dat    = i_dat;
      o_cancel = i_cancel;
    end
  end

  assign push = i_vld & i_rdy & ~byp;
  assign pop  = st_nz & ((o_vld & o_rdy) | drop_st);

  always_comb begin
    cnt_nxt = cnt;
    if (flush) begin
      cnt_nxt = '0;
    end else if (push & ~pop) begin
      cnt_nxt = cnt + CW'(1);
    end else if (pop & ~push) begin
      cnt_nxt = cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  hicore_bypq_ptr #(
    .DP (DP),
    .PW (PW)
  ) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  hicore_bypq_ptr #(
    .DP (DP),
    .PW (PW)
  ) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  // Payload is never reset or cleared; only the cancel bits carry control meaning.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_dat[wr_ptr] <= i_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_cnl <= '0;
    end else if (push) begin
      mem_cnl[wr_ptr] <= i_cancel;
    end
  end

  assign o_cnt       = cnt;
  assign o_empty     = ~st_nz;
  assign o_half_full = (cnt >= CW'(bypq_half(DP)));
  assign o_afull     = (cnt >= CW'(AF_TH));

endmodule

// File: tb/tb_hicore_bypq.sv
// Bench for hicore_bypq: three configurations share one stimulus stream and
// are checked every cycle against a queue model plus directed literal checks.
module tb_hicore_bypq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        i_vld = 1'b0;
  logic [31:0] i_dat = 32'h0;
  logic        i_cancel = 1'b0;
  logic        o_rdy = 1'b0;

  always #5 clk = ~clk;

  logic        i_rdy_w    [3];
  logic        o_vld_w    [3];
  logic [31:0] o_dat_w    [3];
  logic        o_cancel_w [3];
  logic        o_empty_w  [3];
  logic        o_half_w   [3];
  logic        o_afull_w  [3];
  logic [2:0]  cnt_w      [3];
  logic [2:0]  cnt_a;
  logic [1:0]  cnt_b;
  logic [2:0]  cnt_c;

  assign cnt_w[0] = cnt_a;
  assign cnt_w[1] = {1'b0, cnt_b};
  assign cnt_w[2] = cnt_c;

  // u_a: DP=4 bypass, cancels presented
  hicore_bypq #(.DP(4), .DW(32), .BYPASS(1'b1), .DROP_CANCEL(1'b0), .AF_TH(3)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .i_vld(i_vld), .i_rdy(i_rdy_w[0]), .i_dat(i_dat), .i_cancel(i_cancel),
    .o_vld(o_vld_w[0]), .o_rdy(o_rdy), .o_dat(o_dat_w[0]), .o_cancel(o_cancel_w[0]),
    .o_cnt(cnt_a), .o_empty(o_empty_w[0]), .o_half_full(o_half_w[0]), .o_afull(o_afull_w[0])
  );

  // u_b: DP=3 pure FIFO, cancels dropped
  hicore_bypq #(.DP(3), .DW(32), .BYPASS(1'b0), .DROP_CANCEL(1'b1), .AF_TH(2)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .i_vld(i_vld), .i_rdy(i_rdy_w[1]), .i_dat(i_dat), .i_cancel(i_cancel),
    .o_vld(o_vld_w[1]), .o_rdy(o_rdy), .o_dat(o_dat_w[1]), .o_cancel(o_cancel_w[1]),
    .o_cnt(cnt_b), .o_empty(o_empty_w[1]), .o_half_full(o_half_w[1]), .o_afull(o_afull_w[1])
  );

  // u_c: DP=5 bypass, cancels dropped, afull only when completely full
  hicore_bypq #(.DP(5), .DW(32), .BYPASS(1'b1), .DROP_CANCEL(1'b1), .AF_TH(5)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .i_vld(i_vld), .i_rdy(i_rdy_w[2]), .i_dat(i_dat), .i_cancel(i_cancel),
    .o_vld(o_vld_w[2]), .o_rdy(o_rdy), .o_dat(o_dat_w[2]), .o_cancel(o_cancel_w[2]),
    .o_cnt(cnt_c), .o_empty(o_empty_w[2]), .o_half_full(o_half_w[2]), .o_afull(o_afull_w[2])
  );

  function automatic int cfg_dp(input int k);
    case (k) 0: return 4; 1: return 3; default: return 5; endcase
  endfunction
  function automatic int cfg_byp(input int k);
    case (k) 0: return 1; 1: return 0; default: return 1; endcase
  endfunction
  function automatic int cfg_drop(input int k);
    case (k) 0: return 0; 1: return 1; default: return 1; endcase
  endfunction
  function automatic int cfg_af(input int k);
    case (k) 0: return 3; 1: return 2; default: return 5; endcase
  endfunction

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h at %0t", nm, k, act, exp, $time);
  endtask

  // Model: ordered list of {cancel, data}; head is element 0.
  logic [32:0] mq [3][8];
  int          mn [3] = '{0, 0, 0};

  task automatic model_out(input int k, output bit e_rdy, output bit e_vld,
                           output bit e_has, output logic [32:0] e_head);
    e_rdy  = (mn[k] < cfg_dp(k)) && !flush;
    e_has  = (mn[k] > 0) || (cfg_byp(k) == 1 && i_vld);
    e_head = (mn[k] > 0) ? mq[k][0] : {i_cancel, i_dat};
    e_vld  = !flush && e_has && !(cfg_drop(k) == 1 && e_head[32]);
  endtask

  always @(posedge clk or negedge rst_n) begin
    bit          e_rdy, e_vld, e_has, acc, tak;
    logic [32:0] e_head;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) mn[k] = 0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        model_out(k, e_rdy, e_vld, e_has, e_head);
        if (flush) begin
          mn[k] = 0;
        end else begin
          acc = i_vld && e_rdy;
          tak = e_has && ((e_vld && o_rdy) || (cfg_drop(k) == 1 && e_head[32]));
          if (mn[k] > 0) begin
            if (tak) begin
              for (int j = 0; j < 7; j++) mq[k][j] = mq[k][j+1];
              mn[k]--;
            end
            if (acc) begin
              mq[k][mn[k]] = {i_cancel, i_dat};
              mn[k]++;
            end
          end else if (acc && !tak) begin
            mq[k][0] = {i_cancel, i_dat};
            mn[k] = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    bit          e_rdy, e_vld, e_has;
    logic [32:0] e_head;
    for (int k = 0; k < 3; k++) begin
      model_out(k, e_rdy, e_vld, e_has, e_head);
      chk("i_rdy", k, 32'(i_rdy_w[k]), 32'(e_rdy));
      chk("o_vld", k, 32'(o_vld_w[k]), 32'(e_vld));
      chk("o_cnt", k, 32'(cnt_w[k]), 32'(mn[k]));
      chk("o_empty", k, 32'(o_empty_w[k]), 32'(mn[k] == 0));
      chk("o_half_full", k, 32'(o_half_w[k]), 32'(mn[k] >= cfg_dp(k) / 2));
      chk("o_afull", k, 32'(o_afull_w[k]), 32'(mn[k] >= cfg_af(k)));
      if (e_vld) begin
        chk("o_dat", k, o_dat_w[k], e_head[31:0]);
        chk("o_cancel", k, 32'(o_cancel_w[k]), 32'(e_head[32]));
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] d, input logic c,
                      input logic r, input logic f);
    @(posedge clk);
    #1;
    i_vld = v; i_dat = d; i_cancel = c; o_rdy = r; flush = f;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #2;
    for (int k = 0; k < 3; k++) begin
      chk("rst_cnt", k, 32'(cnt_w[k]), 32'd0);
      chk("rst_empty", k, 32'(o_empty_w[k]), 32'd1);
      chk("rst_rdy", k, 32'(i_rdy_w[k]), 32'd1);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Zero-latency bypass on empty queue
    step(1'b1, 32'hA5A5_0001, 1'b0, 1'b1, 1'b0);
    chk("t1_vld", 0, 32'(o_vld_w[0]), 32'd1);
    chk("t1_dat", 0, o_dat_w[0], 32'hA5A5_0001);
    chk("t1_fifo_vld", 1, 32'(o_vld_w[1]), 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("t1_cnt", 0, 32'(cnt_w[0]), 32'd0);
    chk("t1_fifo_dat", 1, o_dat_w[1], 32'hA5A5_0001);

    // Fill DP=3 until full, then drain in order, then refill across the wrap
    for (int i = 1; i <= 3; i++) step(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t2_cnt", 1, 32'(cnt_w[1]), 32'd3);
    chk("t2_rdy", 1, 32'(i_rdy_w[1]), 32'd0);
    chk("t2_afull", 1, 32'(o_afull_w[1]), 32'd1);
    chk("t2_rdy_a", 0, 32'(i_rdy_w[0]), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      chk("t2_drain", 1, o_dat_w[1], 32'(i));
      chk("t2_drain_a", 0, o_dat_w[0], 32'(i));
    end
    for (int i = 4; i <= 6; i++) step(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 4; i <= 6; i++) begin
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      chk("t2_wrap", 1, o_dat_w[1], 32'(i));
    end

    // Two entries held, push and pop every cycle
    step(1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h21, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h22 + 32'(i), 1'b0, 1'b1, 1'b0);
      chk("t3_cnt", 0, 32'(cnt_w[0]), 32'd2);
      chk("t3_dat", 0, o_dat_w[0], 32'h20 + 32'(i));
    end
    repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Cancel handling: presented in u_a, dropped in u_b / u_c
    step(1'b1, 32'h10, 1'b1, 1'b0, 1'b0);
    chk("t4_byp_drop", 2, 32'(o_vld_w[2]), 32'd0);
    step(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
    chk("t4_drop_vld", 1, 32'(o_vld_w[1]), 32'd0);
    chk("t4_keep_dat", 0, o_dat_w[0], 32'h10);
    chk("t4_keep_cnl", 0, 32'(o_cancel_w[0]), 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("t4_next_vld", 1, 32'(o_vld_w[1]), 32'd1);
    chk("t4_next_dat", 1, o_dat_w[1], 32'h11);
    chk("t4_keep_dat2", 0, o_dat_w[0], 32'h10);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("t4_keep_dat3", 0, o_dat_w[0], 32'h11);
    chk("t4_keep_cnl3", 0, 32'(o_cancel_w[0]), 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Flush with three stored entries and a concurrent push
    for (int i = 0; i < 3; i++) step(1'b1, 32'h30 + 32'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h33, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk("t5_rdy", k, 32'(i_rdy_w[k]), 32'd0);
      chk("t5_vld", k, 32'(o_vld_w[k]), 32'd0);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("t5_cnt", k, 32'(cnt_w[k]), 32'd0);
      chk("t5_empty", k, 32'(o_empty_w[k]), 32'd1);
    end

    // Asynchronous reset with two entries stored, no clock edge in between
    step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h41, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t6_pre_cnt", 1, 32'(cnt_w[1]), 32'd2);
    chk("t6_pre_afull", 1, 32'(o_afull_w[1]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("t6_cnt", k, 32'(cnt_w[k]), 32'd0);
      chk("t6_empty", k, 32'(o_empty_w[k]), 32'd1);
      chk("t6_afull", k, 32'(o_afull_w[k]), 32'd0);
    end
    chk("t6_vld", 1, 32'(o_vld_w[1]), 32'd0);
    chk("t6_vld_a", 0, 32'(o_vld_w[0]), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    step(1'b1, 32'h50, 1'b0, 1'b1, 1'b0);
    chk("t7_byp", 2, o_dat_w[2], 32'h50);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("t7_fifo_vld", 1, 32'(o_vld_w[1]), 32'd1);
    chk("t7_fifo_dat", 1, o_dat_w[1], 32'h50);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
